// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch front end for a dual-issue (ALU slot + MEM slot) core.
// Keeps the next fetch PC, issues at most one instruction-memory request at a
// time, and buffers returned 32-bit bundles in a 2-entry FIFO that feeds the
// IF/ID register. A taken branch/jump (redirect) flushes the FIFO and
// restarts fetch; a request already in flight when the redirect arrives is
// completed on the bus and its data thrown away (DISCARD state).
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [15:0] aluInstr,
    output logic [15:0] memInstr,
    output logic [31:0] pc_plus4,
    output logic        bundle_valid
);

    typedef enum logic [0:0] {
        ST_ISSUE   = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_e;

    // Architectural fetch state
    fetch_state_e state_r;
    logic [31:0]  pc_r;          // address of the next bundle to request
    logic [31:0]  hold_addr_r;   // address of the stale request while discarding

    // Bundle FIFO: two entries of {bundle, pc}
    logic [31:0]  fifo_bundle_r [0:1];
    logic [31:0]  fifo_pc_r     [0:1];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   fifo_count_r;

    // Per-cycle control
    logic         req_raw_s;
    logic         ack_s;
    logic         push_s;
    logic         pop_s;
    logic         valid_s;
    logic [31:0]  redirect_target_s;
    logic [31:0]  pc_inc_s;
    logic [31:0]  head_bundle_s;
    logic [31:0]  head_pc_s;

    // Request is wanted whenever the FIFO has room, or unconditionally while
    // a stale request still has to be drained off the bus. Since the FIFO
    // count only grows on an ack, a raised request cannot fall before its ack.
    always_comb begin
        req_raw_s = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                if (fifo_count_r != 2'd2) begin
                    req_raw_s = 1'b1;
                end else begin
                    req_raw_s = 1'b0;
                end
            end
            ST_DISCARD: begin
                req_raw_s = 1'b1;
            end
            default: begin
                req_raw_s = 1'b0;
            end
        endcase
    end

    // Reset gates the request so nothing is presented to memory during reset.
    assign imem_req          = req_raw_s & ~reset;

    // An ack only counts when a request is actually outstanding.
    assign ack_s             = imem_ack & imem_req;
    assign valid_s           = (fifo_count_r != 2'd0);
    assign push_s            = ack_s & (state_r == ST_ISSUE) & ~redirect;
    assign pop_s             = valid_s & ~stall & ~redirect;
    assign redirect_target_s = {redirect_pc[31:2], 2'b00};
    assign pc_inc_s          = pc_r + 32'd4;

    // Address mux: while discarding, the stale address stays on the bus
    // until memory acknowledges it; otherwise the fetch PC is presented.
    always_comb begin
        imem_addr = pc_r;
        if (state_r == ST_DISCARD) begin
            imem_addr = hold_addr_r;
        end else begin
            imem_addr = pc_r;
        end
    end

    // Fetch FSM and PC: redirect wins over everything, an in-flight request
    // interrupted by a redirect is tracked in DISCARD until its ack arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_ISSUE;
            pc_r        <= RESET_PC;
            hold_addr_r <= RESET_PC;
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    if (redirect) begin
                        pc_r <= redirect_target_s;
                        if (req_raw_s && !imem_ack) begin
                            // Request left hanging: keep its address on the bus.
                            state_r     <= ST_DISCARD;
                            hold_addr_r <= pc_r;
                        end else begin
                            // No request, or it completes now and is dropped.
                            state_r <= ST_ISSUE;
                        end
                    end else if (push_s) begin
                        pc_r    <= pc_inc_s;
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DISCARD: begin
                    if (redirect) begin
                        pc_r <= redirect_target_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (imem_ack) begin
                        // Stale data dropped; fetch resumes from pc_r.
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_DISCARD;
                    end
                end
                default: begin
                    state_r <= ST_ISSUE;
                end
            endcase
        end
    end

    // Bundle FIFO storage, pointers and occupancy; a redirect empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_bundle_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]     <= 32'h0000_0000;
            end
            rd_ptr_r     <= 1'b0;
            wr_ptr_r     <= 1'b0;
            fifo_count_r <= 2'd0;
        end else if (redirect) begin
            rd_ptr_r     <= 1'b0;
            wr_ptr_r     <= 1'b0;
            fifo_count_r <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_bundle_r[wr_ptr_r] <= imem_rdata;
                fifo_pc_r[wr_ptr_r]     <= pc_r;
                wr_ptr_r                <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + 2'd1;
                2'b01:   fifo_count_r <= fifo_count_r - 2'd1;
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Head-of-FIFO presentation; everything reads as zero when empty so a
    // flushed slot never leaks old instruction bits downstream.
    always_comb begin
        head_bundle_s = 32'h0000_0000;
        head_pc_s     = 32'h0000_0000;
        pc_plus4      = 32'h0000_0000;
        if (valid_s) begin
            head_bundle_s = fifo_bundle_r[rd_ptr_r];
            head_pc_s     = fifo_pc_r[rd_ptr_r];
            pc_plus4      = head_pc_s + 32'd4;
        end else begin
            head_bundle_s = 32'h0000_0000;
            head_pc_s     = 32'h0000_0000;
            pc_plus4      = 32'h0000_0000;
        end
    end

    assign aluInstr     = head_bundle_s[31:16];
    assign memInstr     = head_bundle_s[15:0];
    assign bundle_valid = valid_s;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed scenarios with a scoreboard: each scenario queues the bundles it
// expects to be accepted downstream; a monitor pops and compares every time
// the fetch unit hands a bundle over. A small memory model answers requests.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [15:0] aluInstr;
    logic [15:0] memInstr;
    logic [31:0] pc_plus4;
    logic        bundle_valid;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [63:0] sb_q[$];
    bit          mem_hold;
    bit          mem_spurious;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .aluInstr     (aluInstr),
        .memInstr     (memInstr),
        .pc_plus4     (pc_plus4),
        .bundle_valid (bundle_valid)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'hABCD_1234;
        else return {16'hC000 ^ a[15:0], 16'h3000 ^ a[15:0]};
    endfunction

    function automatic logic [63:0] bnd(input logic [15:0] a, input logic [15:0] m,
                                        input logic [31:0] p);
        return {a, m, p};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: zero-wait ack unless held; optional spurious ack when idle
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0000_0000;
            end else if (imem_req && !mem_hold) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(imem_addr);
            end else if (!imem_req && mem_spurious) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0000_0000;
            end
        end
    end

    // Monitor: every accepted bundle is compared with the scoreboard head
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && bundle_valid && !stall && !redirect) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL sb_unexpected: got bundle %h_%h pc_plus4 %h, expected none",
                             aluInstr, memInstr, pc_plus4);
                end else begin
                    exp = sb_q.pop_front();
                    check("sb_bundle", {aluInstr, memInstr, pc_plus4}, exp);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset        = 1'b1;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0000_0000;
        mem_hold     = 1'b0;
        mem_spurious = 1'b0;
        @(negedge clk);
        check("rst_req",   imem_req,     64'd0);
        check("rst_valid", bundle_valid, 64'd0);
        check("rst_outs",  {aluInstr, memInstr, pc_plus4}, 64'd0);
        check("rst_addr",  imem_addr,    64'h0);
        @(posedge clk); #1;
    endtask

    task automatic end_scen(input string name);
        do_reset();
        check({name, "_drain"}, sb_q.size(), 64'd0);
        sb_q.delete();
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Redirect while the request to 8 hangs; optionally redirect again in DISCARD
    task automatic scen_redirect(input bit twice);
        sb_q.push_back(bnd(16'hABCD, 16'h1234, 32'h4));
        sb_q.push_back(bnd(16'hC004, 16'h3004, 32'h8));
        if (twice) sb_q.push_back(bnd(16'hC300, 16'h3300, 32'h304));
        else       sb_q.push_back(bnd(16'hC100, 16'h3100, 32'h104));
        release_reset();                                   // C0
        @(negedge clk); check("rd_addr0", imem_addr, 64'h0);
        @(negedge clk); check("rd_addr4", imem_addr, 64'h4);
        @(posedge clk); #1; mem_hold = 1'b1;               // C2
        @(negedge clk); check("rd_addr8", imem_addr, 64'h8);
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_0103;  // C3
        @(negedge clk); check("rd_valid_c3", bundle_valid, 64'd0);
        @(posedge clk); #1; redirect = 1'b0;               // C4
        @(negedge clk); check("rd_hold_c4", {imem_req, imem_addr}, {31'd0, 1'b1, 32'h8});
        @(posedge clk); #1;                                // C5
        if (twice) begin
            redirect    = 1'b1;
            redirect_pc = 32'h0000_0301;
        end
        @(negedge clk); check("rd_hold_c5", {imem_req, imem_addr}, {31'd0, 1'b1, 32'h8});
        @(posedge clk); #1; redirect = 1'b0; mem_hold = 1'b0;  // C6 ack
        @(negedge clk); check("rd_hold_c6", imem_addr, 64'h8);
        @(negedge clk);
        check("rd_newaddr", imem_addr, twice ? 64'h300 : 64'h100);
        check("rd_valid_c7", bundle_valid, 64'd0);
        @(negedge clk);
        check("rd_nextaddr", imem_addr, twice ? 64'h304 : 64'h104);
        check("rd_valid_c8", bundle_valid, 64'd1);
        end_scen(twice ? "redir_discard" : "redir_pending");
    endtask

    // Stimulus
    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0000_0000;
        mem_hold     = 1'b0;
        mem_spurious = 1'b0;
        do_reset();

        // Straight-line fetch, zero wait, no stall
        sb_q.push_back(bnd(16'hABCD, 16'h1234, 32'h4));
        sb_q.push_back(bnd(16'hC004, 16'h3004, 32'h8));
        sb_q.push_back(bnd(16'hC008, 16'h3008, 32'hC));
        release_reset();
        @(negedge clk);
        check("seq_req0",   imem_req,     64'd1);
        check("seq_addr0",  imem_addr,    64'h0);
        check("seq_valid0", bundle_valid, 64'd0);
        @(negedge clk); check("seq_addr4", {bundle_valid, imem_addr}, {31'd0, 1'b1, 32'h4});
        @(negedge clk); check("seq_addr8", imem_addr, 64'h8);
        @(negedge clk); check("seq_addrC", imem_addr, 64'hC);
        end_scen("seq");

        // Stall for 5 cycles from reset release: FIFO fills, request drops
        sb_q.push_back(bnd(16'hABCD, 16'h1234, 32'h4));
        sb_q.push_back(bnd(16'hC004, 16'h3004, 32'h8));
        sb_q.push_back(bnd(16'hC008, 16'h3008, 32'hC));
        stall = 1'b1;
        release_reset();                                   // C0
        @(negedge clk); check("st_addr0", {imem_req, imem_addr}, {31'd0, 1'b1, 32'h0});
        @(negedge clk); check("st_c1", {imem_req, pc_plus4}, {31'd0, 1'b1, 32'h4});
        @(posedge clk); #1; mem_spurious = 1'b1;           // C2
        @(negedge clk); check("st_full_req", imem_req, 64'd0);
        check("st_head", {aluInstr, memInstr, pc_plus4}, bnd(16'hABCD, 16'h1234, 32'h4));
        @(negedge clk);
        @(negedge clk); check("st_hold_c4", {imem_req, bundle_valid, pc_plus4}, {30'd0, 2'b01, 32'h4});
        @(posedge clk); #1; stall = 1'b0; mem_spurious = 1'b0;  // C5
        @(negedge clk); check("st_req_c5", imem_req, 64'd0);
        @(negedge clk); check("st_resume", {imem_req, imem_addr}, {31'd0, 1'b1, 32'h8});
        @(negedge clk);
        end_scen("stall");

        scen_redirect(1'b0);
        scen_redirect(1'b1);

        // Redirect in the same cycle as an ack: data dropped, head flushed
        sb_q.push_back(bnd(16'hC200, 16'h3200, 32'h204));
        release_reset();                                   // C0
        @(negedge clk); check("ra_addr0", imem_addr, 64'h0);
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_0202;  // C1
        @(negedge clk); check("ra_c1", {bundle_valid, imem_addr}, {31'd0, 1'b1, 32'h4});
        @(posedge clk); #1; redirect = 1'b0;               // C2
        @(negedge clk); check("ra_c2", {bundle_valid, imem_addr}, {31'd0, 1'b0, 32'h200});
        @(negedge clk); check("ra_c3", imem_addr, 64'h204);
        end_scen("redir_ack");

        // PC wrap at the top of the address space
        sb_q.push_back(bnd(16'h3FFC, 16'hCFFC, 32'h0));
        sb_q.push_back(bnd(16'hABCD, 16'h1234, 32'h4));
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        release_reset();                                   // C0
        @(negedge clk); check("wr_addr0", imem_addr, 64'h0);
        @(posedge clk); #1; redirect = 1'b0;               // C1
        @(negedge clk); check("wr_c1", {bundle_valid, imem_addr}, {31'd0, 1'b0, 32'hFFFF_FFFC});
        @(negedge clk); check("wr_c2", {bundle_valid, imem_addr}, {31'd0, 1'b1, 32'h0});
        @(negedge clk); check("wr_c3", imem_addr, 64'h4);
        end_scen("wrap");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port stall, input, 1 bit: the IF/ID register is not accepting a bundle this cycle.
REQ-005 SHALL have port redirect, input, 1 bit: a branch or jump is taken; fetch must restart.
REQ-006 SHALL have port redirect_pc, input, 32 bits: the new fetch address, sampled when redirect=1.
REQ-007 SHALL have port imem_req, output, 1 bit: an instruction-memory request is outstanding.
REQ-008 SHALL have port imem_addr, output, 32 bits: the bundle address for the current request.
REQ-009 SHALL have port imem_ack, input, 1 bit: the request completes this cycle; imem_rdata is valid.
REQ-010 SHALL have port imem_rdata, input, 32 bits: the fetched bundle, with [31:16] the ALU-slot instruction and [15:0] the MEM-slot instruction.
REQ-011 SHALL have port aluInstr, output, 16 bits: the ALU-slot instruction of the head bundle.
REQ-012 SHALL have port memInstr, output, 16 bits: the MEM-slot instruction of the head bundle.
REQ-013 SHALL have port pc_plus4, output, 32 bits: the head bundle address + 4.
REQ-014 SHALL have port bundle_valid, output, 1 bit: the head bundle is valid; downstream treats ~bundle_valid as IF_flush.

Function
REQ-015 SHALL hold a PC register and a 2-entry FIFO; each FIFO entry holds {bundle[31:0], pc[31:0]}.
REQ-016 SHALL run a two-state FSM:
- ISSUE: normal fetch.
- DISCARD: a request is outstanding whose data is stale and must be dropped.
REQ-017 In ISSUE, SHALL drive imem_req=1 exactly when fifo_count<2; in DISCARD, imem_req SHALL be 1.
REQ-018 SHALL drive imem_addr = PC; imem_req and imem_addr SHALL stay stable from assertion until the imem_ack cycle, regardless of pops.
REQ-019 SHALL allow at most one outstanding request.
- imem_ack with imem_req=0 SHALL be ignored.
- Data is valid in the same cycle as imem_ack.
REQ-020 On imem_ack in ISSUE with no redirect:
- push {imem_rdata, PC} into the FIFO.
- PC <= PC+4, with the addition wrapping modulo 2^32.
REQ-021 Pop rule: pop the FIFO head when bundle_valid=1 and stall=0; bundle_valid = (fifo_count!=0).
REQ-022 Outputs SHALL come from the FIFO head combinationally:
- aluInstr = head[31:16].
- memInstr = head[15:0].
- pc_plus4 = head_pc+4, wrapping modulo 2^32.
- When the FIFO is empty, outputs SHALL be 0.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged; data order is strictly FIFO.
REQ-024 Redirect has the highest priority:
- FIFO cleared; fifo_count=0.
- PC <= {redirect_pc[31:2], 2'b00}.
- The stall input is ignored that cycle.
REQ-025 Redirect while imem_req=1 and imem_ack=0: next state SHALL be DISCARD, and the old imem_addr SHALL be held until ack.
REQ-026 Redirect in the same cycle as imem_ack: the acked data SHALL be dropped and the FSM SHALL stay in ISSUE; the next request uses the new PC.
REQ-027 In DISCARD, on imem_ack: data SHALL be dropped, PC SHALL be unchanged, and the next state SHALL be ISSUE.
REQ-028 Redirect in DISCARD: PC SHALL be reloaded and the FSM SHALL stay in DISCARD.
REQ-029 The bundle latency from imem_ack to bundle_valid SHALL be 1 cycle.
REQ-030 A full FIFO with stall=1 SHALL keep imem_req=0 and the head SHALL stay unchanged until stall=0.

Reset
REQ-031 While reset=1 (asynchronous):
- PC=RESET_PC, FSM=ISSUE, fifo_count=0, FIFO contents=0.
- imem_req=0 (gated by reset), bundle_valid=0.
- aluInstr=0, memInstr=0, pc_plus4=0, imem_addr=RESET_PC.
REQ-032 SHALL assert imem_req=1 in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-request SHALL abandon the request with no DISCARD state; the memory model is reset alongside.

Verification
REQ-034 Release reset, ack every request at zero wait, no stall -> imem_addr 0,4,8; pc_plus4 sequence 4,8,12; bundle_valid=1 from cycle 2.
REQ-035 imem_rdata=32'hABCD_1234 acked -> next cycle aluInstr=16'hABCD, memInstr=16'h1234.
REQ-036 stall=1 for 5 cycles -> FIFO fills to 2, imem_req drops to 0, head stays at pc_plus4=4; on stall release, bundles 4 then 8 are delivered in order.
REQ-037 redirect=1 with redirect_pc=32'h0000_0103 while a request to 8 is pending and ack arrives 3 cycles later -> ack data dropped, next imem_addr=32'h0000_0100, no bundle from 8 appears.
REQ-038 redirect and imem_ack in the same cycle -> no push; next imem_addr=redirect target.
REQ-039 PC=32'hFFFF_FFFC acked -> pc_plus4=0 and the next imem_addr=0.
